seg7_scan: RTL



---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_lz_mask.sv | 25 ++
 rtl/seg7_scan.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan path: code width, the dash code,
// and a legality check for the scan controller's parameters.
package seg7_pkg;

  localparam int SEG7_CODE_W = 4;

  // Any code above 9 renders as '-' in the decoder; this is the one we emit.
  localparam logic [SEG7_CODE_W-1:0] SEG7_CODE_MINUS = 4'hA;

  // Legal ranges: 1..8 digits, at least 2 cycles per slot, and a dead time
  // shorter than the slot.
  function automatic bit seg7_params_ok(int digits, int tick_div, int blank_cyc);
    return (digits >= 1) && (digits <= 8) && (tick_div >= 2) &&
           (blank_cyc >= 0) && (blank_cyc < tick_div);
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero suppress mask. Digit i (i > 0) is suppressed when lz_en is set
// and it and every more significant digit hold code 0. Digit 0 always shows.
module seg7_lz_mask
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [DIGITS-1:0][SEG7_CODE_W-1:0] active,
  input  logic                               lz_en,
  output logic [DIGITS-1:0]                  suppress
);

  logic upper_zero;

  // Walk down from the most significant digit while everything above is zero.
  always_comb begin
    upper_zero = 1'b1;
    suppress   = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero  = upper_zero && (active[i] == '0);
      suppress[i] = lz_en && upper_zero;
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Every output is registered from the next-cycle (idx, slot_cnt, active)
// values, so each output matches the counter pair held in the same cycle.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          load,
  input  logic [SEG7_CODE_W*DIGITS-1:0] digits_in,
  input  logic                          lz_en,
  output logic [SEG7_CODE_W-1:0]        bcd_out,
  output logic [DIGITS-1:0]             dig_sel,
  output logic                          frame_done
);

  localparam int SW = $clog2(TICK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  if (!seg7_params_ok(DIGITS, TICK_DIV, BLANK_CYC)) begin : g_param_err
    $error("seg7_scan: illegal DIGITS/TICK_DIV/BLANK_CYC combination");
  end

  typedef logic [DIGITS-1:0][SEG7_CODE_W-1:0] frame_t;

  logic [SW-1:0] slot_cnt, slot_n;
  logic [IW-1:0] idx, idx_n;
  frame_t        active, active_n, pending;
  logic          pending_valid;
  logic          lz_q, lz_n;
  logic          restart_q;
  logic          boundary;
  logic          in_blank;
  logic [DIGITS-1:0]      supp_n;
  logic [DIGITS-1:0]      sel_n;
  logic [SEG7_CODE_W-1:0] bcd_n;
  logic                   done_n;

  // Next counter position and frame boundary. After ena has been low the
  // first enabled edge re-enters (0,0) so the restart is a true boundary.
  always_comb begin
    slot_n   = slot_cnt + 1'b1;
    idx_n    = idx;
    boundary = 1'b0;
    if (!ena) begin
      slot_n = '0;
      idx_n  = '0;
    end else if (restart_q) begin
      slot_n   = '0;
      idx_n    = '0;
      boundary = 1'b1;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_n = '0;
      if (idx == IDX_LAST) begin
        idx_n    = '0;
        boundary = 1'b1;
      end else begin
        idx_n = idx + 1'b1;
      end
    end
    active_n = (boundary && pending_valid) ? pending : active;
    lz_n     = (slot_n == '0) ? lz_en : lz_q;
  end

  if (BLANK_CYC == 0) begin : g_noblank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = slot_n < SW'(BLANK_CYC);
  end

  seg7_lz_mask #(.DIGITS(DIGITS)) u_lz_mask (
    .active   (active_n),
    .lz_en    (lz_n),
    .suppress (supp_n)
  );

  // Output values for the next cycle's (idx, slot_cnt).
  always_comb begin
    bcd_n = active_n[idx_n];
    sel_n = '0;
    if (ena && !in_blank && !supp_n[idx_n]) begin
      sel_n = DIGITS'(1) << idx_n;
    end
    done_n = ena && (idx_n == IDX_LAST) && (slot_n == SLOT_LAST);
  end

  // Counters and frame buffers; a load on the boundary edge is not bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt      <= '0;
      idx           <= '0;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      lz_q          <= 1'b0;
      restart_q     <= 1'b0;
    end else begin
      slot_cnt  <= slot_n;
      idx       <= idx_n;
      active    <= active_n;
      lz_q      <= lz_n;
      restart_q <= !ena;
      if (load) begin
        pending       <= digits_in;
        pending_valid <= 1'b1;
      end else if (boundary && pending_valid) begin
        pending_valid <= 1'b0;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out    <= '0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      bcd_out    <= bcd_n;
      dig_sel    <= sel_n;
      frame_done <= done_n;
    end
  end

endmodule
